// File: rtl/alu_sequencer.sv
// alu_sequencer: command front-end for a Hack-style 16-bit ALU; runs one ALU op or a shift-add multiply per command.
// Latency: ALU op 2 cycles accept-to-rsp_valid; MUL MUL_STEPS+1 cycles (ALU_SEQ_MUL_EARLY_EXIT_EN: highest set bit of y + 2).
// Backpressure: one command in flight; cmd_ready is low from accept until the response is taken with rsp_ready.
module alu_sequencer #(
    parameter int WIDTH     = 16,
    parameter int MUL_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [5:0]       cmd_ctrl,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zr,
    output logic             rsp_ng,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zr,
    input  logic             alu_ng
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ALU  = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int            CW       = $clog2(MUL_STEPS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_STEPS - 1);
    localparam logic [5:0]    CTRL_ADD = 6'b000010;
    localparam logic [5:0]    CTRL_OFF = 6'b000000;

    logic [1:0]       state_q,      state_d;
    logic [5:0]       ctrl_q,       ctrl_d;
    logic [WIDTH-1:0] acc_q,        acc_d;
    logic [WIDTH-1:0] mcand_q,      mcand_d;
    logic [WIDTH-1:0] mplier_q,     mplier_d;
    logic [CW-1:0]    count_q,      count_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zr_q,     rsp_zr_d;
    logic             rsp_ng_q,     rsp_ng_d;
    logic [WIDTH-1:0] alu_x_q,      alu_x_d;
    logic [WIDTH-1:0] alu_y_q,      alu_y_d;

    logic             mul_last;

    // Decide whether the current multiply iteration is the final one.
    always_comb begin
        mul_last = (count_q == CNT_LAST);
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        // Once no multiplier bits remain after this step, later steps could only add zero.
        if ((mplier_q >> 1) == '0) begin
            mul_last = 1'b1;
        end
`endif
    end

    // Handshake outputs and ALU control follow the state directly.
    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        rsp_valid  = (state_q == ST_DONE);
        rsp_result = rsp_result_q;
        rsp_zr     = rsp_zr_q;
        rsp_ng     = rsp_ng_q;
        alu_x      = alu_x_q;
        alu_y      = alu_y_q;
        case (state_q)
            ST_ALU:  alu_ctrl = ctrl_q;
            ST_MUL:  alu_ctrl = CTRL_ADD;
            default: alu_ctrl = CTRL_OFF;
        endcase
    end

    // Next-state, datapath and operand-register updates.
    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        count_d      = count_q;
        rsp_result_d = rsp_result_q;
        rsp_zr_d     = rsp_zr_q;
        rsp_ng_d     = rsp_ng_q;
        alu_x_d      = alu_x_q;
        alu_y_d      = alu_y_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    ctrl_d = cmd_ctrl;
                    if (cmd_op) begin
                        state_d  = ST_MUL;
                        acc_d    = '0;
                        mcand_d  = cmd_x;
                        mplier_d = cmd_y;
                        count_d  = '0;
                        // ALU operand registers mirror acc/mcand so the first add is ready next cycle.
                        alu_x_d  = '0;
                        alu_y_d  = cmd_x;
                    end else begin
                        state_d = ST_ALU;
                        alu_x_d = cmd_x;
                        alu_y_d = cmd_y;
                    end
                end
            end
            ST_ALU: begin
                rsp_result_d = alu_result;
                rsp_zr_d     = alu_zr;
                rsp_ng_d     = alu_ng;
                state_d      = ST_DONE;
            end
            ST_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (mul_last) begin
                    // Flags come from the accumulated value, not the ALU, since the
                    // last ALU output may have been discarded (multiplier bit clear).
                    rsp_result_d = acc_d;
                    rsp_zr_d     = (acc_d == '0);
                    rsp_ng_d     = acc_d[WIDTH-1];
                    state_d      = ST_DONE;
                end else begin
                    alu_x_d = acc_d;
                    alu_y_d = mcand_d;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset to idle and zeroed datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ctrl_q       <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            count_q      <= '0;
            rsp_result_q <= '0;
            rsp_zr_q     <= 1'b0;
            rsp_ng_q     <= 1'b0;
            alu_x_q      <= '0;
            alu_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            count_q      <= count_d;
            rsp_result_q <= rsp_result_d;
            rsp_zr_q     <= rsp_zr_d;
            rsp_ng_q     <= rsp_ng_d;
            alu_x_q      <= alu_x_d;
            alu_y_q      <= alu_y_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer with directed and random commands against a reference model.
// Latency: checks accept-to-rsp_valid cycle counts for ALU and MUL commands.
// Backpressure: exercises response stalls, ignored commands while busy and mid-multiply reset.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [5:0]  cmd_ctrl;
    logic [15:0] cmd_x;
    logic [15:0] cmd_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_zr;
    logic        rsp_ng;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_result;
    logic        alu_zr;
    logic        alu_ng;

    int n_chk  = 0;
    int n_fail = 0;

    alu_sequencer #(.WIDTH(16), .MUL_STEPS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_ctrl   (cmd_ctrl),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zr     (rsp_zr),
        .rsp_ng     (rsp_ng),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng)
    );

    always #5 clk = ~clk;

    // Hack ALU: {zx,nx,zy,ny,f,no}
    function automatic logic [15:0] hack(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] a, b, o;
        a = c[5] ? 16'h0 : x;
        a = c[4] ? ~a : a;
        b = c[3] ? 16'h0 : y;
        b = c[2] ? ~b : b;
        o = c[1] ? (a + b) : (a & b);
        return c[0] ? ~o : o;
    endfunction

    assign alu_result = hack(alu_x, alu_y, alu_ctrl);
    assign alu_zr     = (alu_result == 16'h0);
    assign alu_ng     = alu_result[15];

    function automatic logic [15:0] ref_result(input logic op, input logic [5:0] c,
                                               input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        if (!op) return hack(x, y, c);
        p = {16'h0, x} * {16'h0, y};
        return p[15:0];
    endfunction

    function automatic int ref_latency(input logic op, input logic [15:0] y);
        int h;
        if (!op) return 2;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        h = 0;
        for (int i = 0; i < 16; i++) if (y[i]) h = i;
        return h + 2;
`else
        h = y[0] ? 0 : 0;
        return 16 + 1 + h;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge and count falling edges until rsp_valid.
    task automatic issue(input logic op, input logic [5:0] c, input logic [15:0] x,
                         input logic [15:0] y, input string tag, output int lat);
        chk({tag, "_accept_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ctrl  = c;
        cmd_x     = x;
        cmd_y     = y;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
            if (rsp_valid) break;
        end
    endtask

    task automatic check_rsp(input string tag, input int lat, input int exp_lat, input logic [15:0] er);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"},  32'(rsp_result), 32'(er));
        chk({tag, "_zr"},      32'(rsp_zr), 32'(er == 16'h0));
        chk({tag, "_ng"},      32'(rsp_ng), 32'(er[15]));
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic op, input logic [5:0] c, input logic [15:0] x,
                           input logic [15:0] y, input string tag);
        int lat;
        issue(op, c, x, y, tag, lat);
        check_rsp(tag, lat, ref_latency(op, y), ref_result(op, c, x, y));
        finish_rsp(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},  32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"},  32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        chk({tag, "_rsp_zr"},     32'(rsp_zr), 32'd0);
        chk({tag, "_rsp_ng"},     32'(rsp_ng), 32'd0);
        chk({tag, "_alu_x"},      32'(alu_x), 32'd0);
        chk({tag, "_alu_y"},      32'(alu_y), 32'd0);
        chk({tag, "_alu_ctrl"},   32'(alu_ctrl), 32'd0);
    endtask

    initial begin
        int          lat;
        int          seen;
        logic        op;
        logic [5:0]  c;
        logic [15:0] x, y;

        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_ctrl  = 6'h0;
        cmd_x     = 16'h0;
        cmd_y     = 16'h0;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed ALU and MUL commands
        run_cmd(1'b0, 6'b000010, 16'd3, 16'd4, "alu_add");
        run_cmd(1'b0, 6'b010011, 16'd5, 16'd9, "alu_sub");
        run_cmd(1'b0, 6'b101010, 16'h1234, 16'h5678, "alu_zero");
        run_cmd(1'b1, 6'b000000, 16'd7, 16'd6, "mul_7x6");
        run_cmd(1'b1, 6'b000000, 16'hFFFF, 16'hFFFF, "mul_ffff");
        run_cmd(1'b1, 6'b000000, 16'h0100, 16'h0100, "mul_wrap0");
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        run_cmd(1'b1, 6'b000000, 16'd9, 16'd2, "early_9x2");
        run_cmd(1'b1, 6'b000000, 16'd1234, 16'd0, "early_y0");
`endif

        // Response backpressure with an ignored command pulse during the stall
        issue(1'b1, 6'b000000, 16'd12, 16'd11, "stall", lat);
        check_rsp("stall", lat, ref_latency(1'b1, 16'd11), 16'd132);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                cmd_valid = 1'b1;
                cmd_op    = 1'b0;
                cmd_ctrl  = 6'b101010;
                cmd_x     = 16'd77;
                cmd_y     = 16'd88;
            end
            if (i == 4) cmd_valid = 1'b0;
            chk("stall_result", 32'(rsp_result), 32'd132);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        finish_rsp("stall");
        run_cmd(1'b0, 6'b000010, 16'd1000, 16'd23, "after_stall");

        // Asynchronous reset in the middle of a multiply
        chk("rst_accept_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_x     = 16'd100;
        cmd_y     = 16'd200;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        chk("rst_mid_busy", 32'(cmd_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        chk("rst_idle_ready", 32'(cmd_ready), 32'd1);

        // Random commands against the reference model
        for (int i = 0; i < 24; i++) begin
            op = 1'($urandom_range(0, 1));
            c  = 6'($urandom);
            x  = 16'($urandom);
            y  = (i % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            run_cmd(op, c, x, y, op ? "rand_mul" : "rand_alu");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
